// File: rtl/nn_fixed_pkg.sv
// Shared Q5.10 fixed-point constants and the MAC state encoding.
// Used by dense_neuron_mac and by the later neuron stages.
package nn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/round_sat.sv
// Round-half-up an accumulator holding 2*FRAC_W fractional bits down to a
// FRAC_W-fraction word, clamping to SAT_MAX/SAT_MIN. Purely combinational.
module round_sat #(
  parameter int ACC_W  = 40,
  parameter int DATA_W = nn_fixed_pkg::DATA_W,
  parameter int FRAC_W = nn_fixed_pkg::FRAC_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] data,
  output logic                     sat
);
  import nn_fixed_pkg::*;

  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic [ACC_W-DATA_W+1:0]  top;

  always_comb begin
    // One guard bit so adding the half-LSB can never wrap.
    rounded = {acc[ACC_W-1], acc} + HALF;
    shifted = rounded >>> FRAC_W;
    top     = shifted[ACC_W:DATA_W-1];
    sat     = !((&top) || !(|top));
    if (!sat)
      data = shifted[DATA_W-1:0];
    else if (shifted[ACC_W])
      data = SAT_MIN;
    else
      data = SAT_MAX;
  end

endmodule

// File: rtl/dense_neuron_mac.sv
// Single-neuron MAC: y = bias + sum(x[i]*w[i]) over N_INPUTS pairs, rounded and
// saturated to Q5.10. Define MAC_SAT_FLAG_EN to add the sat_flag output.
//
// state    | meaning
// ST_IDLE  | waiting for start; bias latched into acc when it arrives
// ST_ACCUM | accepting operand pairs, products folded one cycle behind
// ST_DRAIN | last product folding into acc, then result is rounded
// ST_DONE  | data_out valid, held until out_ready
module dense_neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = nn_fixed_pkg::DATA_W,
  parameter int FRAC_W   = nn_fixed_pkg::FRAC_W,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
`ifdef MAC_SAT_FLAG_EN
  ,
  output logic              sat_flag
`endif
);
  import nn_fixed_pkg::*;

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  mac_state_t               state, state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  bias_aligned;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [PROD_W-1:0] p_q;
  logic signed [PROD_W-1:0] prod;
  logic                     p_vld;
  logic [CNT_W-1:0]         cnt;
  logic                     beat;
  logic                     load;
  logic                     take;
  logic [DATA_W-1:0]        rs_data;
  logic                     rs_sat;

  assign beat         = in_valid & in_ready;
  assign prod         = $signed(x_in) * $signed(w_in);
  assign p_ext        = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
  assign bias_aligned = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    load      = 1'b0;
    take      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = ST_DRAIN;
      end
      // Stay until the product register is empty so acc is final when rounded.
      ST_DRAIN: begin
        if (!p_vld) begin
          take      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (start) begin
            load      = 1'b1;
            state_nxt = ST_ACCUM;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      p_q   <= '0;
      p_vld <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= bias_aligned;
      p_vld <= 1'b0;
      cnt   <= '0;
    end else begin
      if (p_vld) acc <= acc + p_ext;
      p_vld <= beat;
      if (beat) begin
        p_q <= prod;
        cnt <= cnt + 1'b1;
      end
    end
  end

  round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc (acc),
    .data(rs_data),
    .sat (rs_sat)
  );

`ifdef MAC_SAT_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      sat_flag <= 1'b0;
    end else if (take) begin
      data_out <= rs_data;
      sat_flag <= rs_sat;
    end
  end
`else
  // Clamp indication has no consumer in this build.
  logic sat_unused;
  assign sat_unused = rs_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     data_out <= '0;
    else if (take) data_out <= rs_data;
  end
`endif

endmodule

// File: tb/tb_dense_neuron_mac.sv
// Directed and randomized bench for dense_neuron_mac with an arithmetic
// reference model; define MAC_SAT_FLAG_EN to also check sat_flag.
module tb_dense_neuron_mac;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        busy;
`ifdef MAC_SAT_FLAG_EN
  logic        sat_flag;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] xs [N];
  logic [15:0] ws [N];
  logic [15:0] cur_bias;

  dense_neuron_mac dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
`ifdef MAC_SAT_FLAG_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact real-valued sum in Q.20, rounded half-up to Q.10 and clamped.
  function automatic logic [16:0] model();
    longint s;
    s = longint'($signed(cur_bias)) * 1024;
    for (int i = 0; i < N; i++)
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    s = (s + 512) >>> 10;
    if (s > 32767)       return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, s[15:0]};
  endfunction

  function automatic logic [15:0] small_rand();
    logic [15:0] v;
    v = 16'($urandom_range(0, 4095)) - 16'd2048;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_from_idle(input string tag);
    bias  = cur_bias;
    start = 1'b1;
    tick();
    start = 1'b0;
    bias  = 16'($urandom);
    check({tag, "_accum_rdy"}, in_ready, 1);
    check({tag, "_accum_busy"}, busy, 1);
  endtask

  task automatic send_pair(input string tag, input logic [15:0] x, input logic [15:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    x_in     = x;
    w_in     = w;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy_wait"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    x_in     = 16'($urandom);
    w_in     = 16'($urandom);
  endtask

  task automatic feed(input string tag, input int gap_max, input bit poke_start);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        if (poke_start) begin
          start = 1'b1;
          bias  = 16'($urandom);
        end
        tick();
        start = 1'b0;
      end
      send_pair(tag, xs[i], ws[i]);
    end
  endtask

  // Called one step after the edge that took the last beat.
  task automatic finish_check(input string tag, input int hold);
    logic [16:0] exp;
    exp = model();
    check({tag, "_e0_valid"}, out_valid, 0);
    check({tag, "_e0_rdy"}, in_ready, 0);
    tick();
    check({tag, "_e1_valid"}, out_valid, 0);
    tick();
    check({tag, "_e2_valid"}, out_valid, 1);
    check({tag, "_data"}, data_out, exp[15:0]);
`ifdef MAC_SAT_FLAG_EN
    check({tag, "_sat"}, sat_flag, exp[16]);
`endif
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      bias  = 16'($urandom);
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_data"}, data_out, exp[15:0]);
    end
    start = 1'b0;
  endtask

  task automatic handshake_idle(input string tag, input logic [15:0] last);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, out_valid, 0);
    check({tag, "_hs_busy"}, busy, 0);
    check({tag, "_hs_keep"}, data_out, last);
  endtask

  task automatic handshake_restart(input string tag);
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = cur_bias;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    bias      = 16'($urandom);
    check({tag, "_b2b_valid"}, out_valid, 0);
    check({tag, "_b2b_rdy"}, in_ready, 1);
  endtask

  task automatic fill(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  initial begin
    logic [16:0] e;
    reset     = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    x_in      = '0;
    w_in      = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
`ifdef MAC_SAT_FLAG_EN
    check("rst_sat", sat_flag, 0);
`endif
    reset = 1'b0;
    tick();

    cur_bias = 16'h0000;
    fill(16'h0400, 16'h0400);
    begin_from_idle("unity");
    feed("unity", 0, 0);
    finish_check("unity", 0);
    check("unity_const", data_out, 16'h2000);
    handshake_idle("unity", 16'h2000);

    // Pairs offered while idle must not count as beats.
    in_valid = 1'b1;
    x_in     = 16'h7FFF;
    w_in     = 16'h7FFF;
    repeat (3) tick();
    in_valid = 1'b0;
    cur_bias = 16'h0400;
    fill(16'hFC00, 16'h0200);
    begin_from_idle("neg");
    feed("neg", 0, 0);
    finish_check("neg", 0);
    check("neg_const", data_out, 16'hF400);
    handshake_idle("neg", 16'hF400);

    cur_bias = 16'h0000;
    fill(16'h0000, 16'h0000);
    xs[0] = 16'h0001;
    ws[0] = 16'h0200;
    begin_from_idle("round");
    feed("round", 0, 0);
    finish_check("round", 0);
    check("round_const", data_out, 16'h0001);
    handshake_idle("round", 16'h0001);

    fill(16'h7FFF, 16'h7FFF);
    begin_from_idle("satmax");
    feed("satmax", 0, 0);
    finish_check("satmax", 0);
    check("satmax_const", data_out, 16'h7FFF);
    handshake_idle("satmax", 16'h7FFF);

    fill(16'h7FFF, 16'h8000);
    begin_from_idle("satmin");
    feed("satmin", 0, 0);
    finish_check("satmin", 0);
    check("satmin_const", data_out, 16'h8000);
    handshake_idle("satmin", 16'h8000);

    // Bubbles, stray start pulses, held output, then back-to-back neurons.
    cur_bias = small_rand();
    for (int i = 0; i < N; i++) begin
      xs[i] = small_rand();
      ws[i] = small_rand();
    end
    begin_from_idle("bub");
    feed("bub", 3, 1);
    finish_check("bub", 5);
    for (int k = 0; k < 6; k++) begin
      cur_bias = ($urandom_range(0, 3) == 0) ? 16'($urandom) : small_rand();
      for (int i = 0; i < N; i++) begin
        xs[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : small_rand();
        ws[i] = small_rand();
      end
      handshake_restart("rnd");
      feed("rnd", 2, k[0]);
      finish_check("rnd", $urandom_range(0, 2));
    end
    e = model();
    handshake_idle("rnd_end", e[15:0]);

    // Abort after four beats: everything clears at once, no result appears.
    cur_bias = 16'h0400;
    fill(16'h0400, 16'h0400);
    begin_from_idle("abort");
    for (int i = 0; i < 4; i++) send_pair("abort", xs[i], ws[i]);
    reset = 1'b1;
    #1;
    check("abort_rdy", in_ready, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", data_out, 0);
    tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end

    cur_bias = 16'h0000;
    begin_from_idle("unity2");
    feed("unity2", 1, 0);
    finish_check("unity2", 0);
    check("unity2_const", data_out, 16'h2000);
    handshake_idle("unity2", 16'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
